// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - samples a multiplexed active-low 7-segment bus and decodes stable glyphs to hex nibbles.
// Optional macro SEGDEC_BLANK_EN: accept 0x7F (all segments off) as a legal blank digit.
module seg_scan_decoder #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  capture,
    output logic                  frame_done,
    output logic                  err
);

    localparam int         IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);
    localparam logic [6:0] BLANK    = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [6:0]            seg_s_q;
    logic [DIGITS-1:0]     an_s_q;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            pat_q, pat_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   value_q, value_d;
    logic [DIGITS-1:0]     valid_q, valid_d;
    logic [DIGITS-1:0]     mask_q, mask_d;
    logic                  capture_q, capture_d;
    logic                  frame_q, frame_d;
    logic                  err_q, err_d;

    logic [DIGITS-1:0]     sel;
    logic                  one_hot;
    logic                  multi;
    logic [IDX_W-1:0]      sel_idx;
    logic                  same;
    logic                  enter;
    logic                  accept;
    logic [4:0]            dec;
    logic [DIGITS-1:0]     mask_set;

    // Returns {recognised, nibble}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s_q   <= BLANK;
            an_s_q    <= '1;
            state_q   <= IDLE;
            idx_q     <= '0;
            pat_q     <= '0;
            cnt_q     <= '0;
            value_q   <= '0;
            valid_q   <= '0;
            mask_q    <= '0;
            capture_q <= 1'b0;
            frame_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            seg_s_q   <= seg_n;
            an_s_q    <= an_n;
            state_q   <= state_d;
            idx_q     <= idx_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            mask_q    <= mask_d;
            capture_q <= capture_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        sel     = ~an_s_q;
        one_hot = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
        multi   = (sel != '0) && !one_hot;
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        same = one_hot && (sel_idx == idx_q) && (seg_s_q == pat_q);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        value_d   = value_q;
        valid_d   = valid_q;
        mask_d    = mask_q;
        capture_d = 1'b0;
        frame_d   = 1'b0;
        err_d     = err_q;
        enter     = 1'b0;
        accept    = 1'b0;
        dec       = decode(pat_q);
        mask_set  = mask_q | (DIGITS'(1) << idx_q);

        case (state_q)
            IDLE: begin
                enter = 1'b1;
            end
            SETTLE: begin
                if (same) begin
                    if (cnt_q == STABLE_C) begin
                        accept  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    enter = 1'b1;
                end
            end
            HOLD: begin
                if (!same) begin
                    enter = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A change from any state re-runs the entry rules on the current sample.
        if (enter) begin
            if (one_hot) begin
                state_d = SETTLE;
                idx_d   = sel_idx;
                pat_d   = seg_s_q;
                cnt_d   = 8'd1;
            end else begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                if (multi) begin
                    err_d = 1'b1;
                end
            end
        end

        if (accept) begin
            if (dec[4]) begin
                value_d[{idx_q, 2'b00} +: 4] = dec[3:0];
                valid_d[idx_q]               = 1'b1;
                capture_d                    = 1'b1;
                if (&mask_set) begin
                    frame_d = 1'b1;
                    mask_d  = '0;
                end else begin
                    mask_d = mask_set;
                end
`ifdef SEGDEC_BLANK_EN
            end else if (pat_q == BLANK) begin
                value_d[{idx_q, 2'b00} +: 4] = 4'h0;
                valid_d[idx_q]               = 1'b0;
                capture_d                    = 1'b1;
                if (&mask_set) begin
                    frame_d = 1'b1;
                    mask_d  = '0;
                end else begin
                    mask_d = mask_set;
                end
`endif
            end else begin
                valid_d[idx_q] = 1'b0;
                err_d          = 1'b1;
            end
        end
    end

    assign value       = value_q;
    assign digit_valid = valid_q;
    assign capture     = capture_q;
    assign frame_done  = frame_q;
    assign err         = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder with a run-length reference model.
module tb_seg_scan_decoder;

    localparam int D = 8;
    localparam int S = 4;
    localparam int W = 4 * D + D + 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [6:0]      seg_n = 7'h7F;
    logic [D-1:0]    an_n = '1;
    logic [4*D-1:0]  value;
    logic [D-1:0]    digit_valid;
    logic            capture;
    logic            frame_done;
    logic            err;

    seg_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .value       (value),
        .digit_valid (digit_valid),
        .capture     (capture),
        .frame_done  (frame_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int caps, frames, fd_alone, first_cap;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference: a glyph is accepted when the same single-digit sample has been
    // seen by the decoder on exactly STABLE_CYCLES+1 consecutive cycles.
    logic [D-1:0]   m_an_s, m_key_an;
    logic [6:0]     m_seg_s, m_key_seg;
    int             m_run;
    logic [4*D-1:0] m_value;
    logic [D-1:0]   m_valid, m_mask;
    logic           m_cap, m_fd, m_err;
    wire  [W-1:0]   exp_vec = {m_value, m_valid, m_cap, m_fd, m_err};
    wire  [W-1:0]   dut_vec = {value, digit_valid, capture, frame_done, err};

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (glyph[i] == p) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        int nlow, idx, code;
        bit good, blank;
        if (rst) begin
            m_an_s = '1; m_seg_s = 7'h7F; m_run = 0;
            m_value = '0; m_valid = '0; m_mask = '0;
            m_cap = 0; m_fd = 0; m_err = 0;
        end else begin
            m_cap = 0; m_fd = 0;
            nlow = $countones(~m_an_s);
            if (nlow != 1) begin
                m_run = 0;
                if (nlow > 1) m_err = 1;
            end else begin
                if (m_run > 0 && m_an_s == m_key_an && m_seg_s == m_key_seg) m_run++;
                else begin m_run = 1; m_key_an = m_an_s; m_key_seg = m_seg_s; end
                if (m_run == S + 1) begin
                    idx = 0;
                    for (int i = 0; i < D; i++) if (!m_key_an[i]) idx = i;
                    code = lookup(m_key_seg);
                    blank = 0;
`ifdef SEGDEC_BLANK_EN
                    blank = (m_key_seg == 7'h7F);
`endif
                    good = (code >= 0) || blank;
                    if (good) begin
                        m_value[idx*4 +: 4] = blank ? 4'h0 : 4'(code);
                        m_valid[idx] = !blank;
                        m_cap = 1;
                        m_mask[idx] = 1;
                        if (&m_mask) begin m_fd = 1; m_mask = '0; end
                    end else begin
                        m_valid[idx] = 0;
                        m_err = 1;
                    end
                end
            end
            m_an_s = an_n; m_seg_s = seg_n;
        end
    end

    task automatic hold(input logic [D-1:0] a, input logic [6:0] s, input int n, input logic r);
        caps = 0; frames = 0; fd_alone = 0; first_cap = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            an_n = a; seg_n = s; rst = r;
            @(posedge clk);
            #1;
            if (capture === 1'b1) begin caps++; if (first_cap < 0) first_cap = i; end
            if (frame_done === 1'b1) begin frames++; if (capture !== 1'b1) fd_alone++; end
        end
    endtask

    task automatic test_reset;
        hold('1, 7'h7F, 3, 1'b1);
        checks++; if (dut_vec !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", dut_vec); end
        hold('1, 7'h7F, 2, 1'b0);
        checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL reset_idle got %h want %h", dut_vec, exp_vec); end
    endtask

    task automatic test_single;
        hold('1, 7'h7F, 2, 1'b1);
        hold(8'hFE, 7'h30, 10, 1'b0);
        checks++; if (caps != 1) begin errors++; $display("FAIL single_caps got %0d want 1", caps); end
        checks++; if (first_cap != S + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", first_cap, S + 2); end
        checks++; if (value[3:0] !== 4'h3) begin errors++; $display("FAIL single_value got %h want 3", value[3:0]); end
        checks++; if (digit_valid !== 8'h01) begin errors++; $display("FAIL single_valid got %h want 01", digit_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", err); end
        checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL single_model got %h want %h", dut_vec, exp_vec); end
    endtask

    task automatic test_glitch;
        int c1;
        hold('1, 7'h7F, 2, 1'b1);
        hold(8'hFE, 7'h30, S - 1, 1'b0);
        c1 = caps;
        hold(8'hFE, 7'h19, 10, 1'b0);
        checks++; if (c1 != 0 || caps != 1) begin errors++; $display("FAIL glitch_caps got %0d/%0d want 0/1", c1, caps); end
        checks++; if (value[3:0] !== 4'h4) begin errors++; $display("FAIL glitch_value got %h want 4", value[3:0]); end
    endtask

    task automatic test_full_scan;
        logic [6:0] pats [8] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
        int tc, tf, ta;
        hold('1, 7'h7F, 2, 1'b1);
        tc = 0; tf = 0; ta = 0;
        for (int d = 0; d < D; d++) begin
            hold(~(8'h01 << d), pats[d], 8, 1'b0);
            tc += caps; tf += frames; ta += fd_alone;
        end
        checks++; if (value !== 32'h87654321) begin errors++; $display("FAIL scan_value got %h want 87654321", value); end
        checks++; if (tc != 8 || tf != 1 || ta != 0 || frames != 1) begin
            errors++; $display("FAIL scan_frame got caps=%0d frames=%0d lone=%0d last=%0d want 8/1/0/1", tc, tf, ta, frames);
        end
        checks++; if (digit_valid !== 8'hFF) begin errors++; $display("FAIL scan_valid got %h want ff", digit_valid); end
    endtask

    task automatic test_illegal;
        hold('1, 7'h7F, 2, 1'b1);
        hold(8'hFE, 7'h30, 10, 1'b0);
        hold(8'hFC, 7'h30, 4, 1'b0);
        checks++; if (err !== 1'b1 || caps != 0) begin errors++; $display("FAIL illegal_an err=%b caps=%0d want 1/0", err, caps); end
        hold(8'hFD, 7'h7F, 10, 1'b0);
        checks++; if (err !== 1'b1 || value[3:0] !== 4'h3 || value[7:4] !== 4'h0) begin
            errors++; $display("FAIL illegal_sticky err=%b value=%h want 1 and ..03", err, value[7:0]);
        end
        checks++; if (digit_valid !== 8'h01) begin errors++; $display("FAIL illegal_valid got %h want 01", digit_valid); end
`ifndef SEGDEC_BLANK_EN
        checks++; if (caps != 0) begin errors++; $display("FAIL illegal_nocap got %0d want 0", caps); end
`endif
        checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL illegal_model got %h want %h", dut_vec, exp_vec); end
    endtask

`ifdef SEGDEC_BLANK_EN
    task automatic test_blank;
        hold('1, 7'h7F, 2, 1'b1);
        hold(8'hFB, 7'h06, 8, 1'b0);
        hold(8'hFB, 7'h7F, 8, 1'b0);
        checks++; if (caps != 1) begin errors++; $display("FAIL blank_caps got %0d want 1", caps); end
        checks++; if (value[11:8] !== 4'h0 || digit_valid[2] !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL blank_state value=%h valid=%b err=%b want 0/0/0", value[11:8], digit_valid[2], err);
        end
    endtask
`endif

    task automatic test_reset_mid;
        hold('1, 7'h7F, 2, 1'b1);
        hold(8'hFE, 7'h24, 3, 1'b0);
        hold(8'hFE, 7'h24, 1, 1'b1);
        checks++; if (caps != 0 || dut_vec !== '0) begin errors++; $display("FAIL rstmid_clear caps=%0d got %h want 0", caps, dut_vec); end
        hold(8'hFE, 7'h24, 10, 1'b0);
        checks++; if (caps != 1 || first_cap != S + 2 || value[3:0] !== 4'h2) begin
            errors++; $display("FAIL rstmid_recover caps=%0d at=%0d value=%h want 1/%0d/2", caps, first_cap, value[3:0], S + 2);
        end
    endtask

    task automatic test_random;
        logic [D-1:0] a;
        logic [6:0]   s;
        logic         r;
        int n, k, j;
        hold('1, 7'h7F, 2, 1'b1);
        for (int seg_i = 0; seg_i < 300; seg_i++) begin
            k = $urandom_range(0, 19);
            if (k == 0) a = '1;
            else if (k == 1) begin
                j = $urandom_range(0, D - 1);
                a = ~((8'h01 << j) | (8'h01 << ((j + 1) % D)));
            end else a = ~(8'h01 << $urandom_range(0, D - 1));
            k = $urandom_range(0, 19);
            if (k == 0) s = 7'h7F;
            else if (k == 1) s = 7'($urandom);
            else s = glyph[$urandom_range(0, 15)];
            r = ($urandom_range(0, 39) == 0);
            n = $urandom_range(1, 8);
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                an_n = a; seg_n = s; rst = r && (c == 0);
                @(posedge clk);
                #1;
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++; $display("FAIL random_cycle seg=%0d got %h want %h", seg_i, dut_vec, exp_vec);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_glitch;
        test_full_scan;
        test_illegal;
`ifdef SEGDEC_BLANK_EN
        test_blank;
`endif
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
